// File: rtl/temp_band_pkg.sv
// Shared FSM state type, width helpers and default parameters for the temperature band indicator.
package temp_band_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TRIG = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam int DEF_TEMP_W     = 8;
  localparam int DEF_NUM_BANDS  = 3;
  localparam int DEF_SAMPLE_DIV = 100;
  localparam int DEF_TRIG_W     = 4;
  localparam int DEF_HYST       = 2;
  localparam int DEF_BLINK_DIV  = 8;

  // Band index must also encode the over-range band NUM_BANDS.
  function automatic int band_w(input int num_bands);
    return $clog2(num_bands + 1);
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/temp_band_sample_timer.sv
// Free-running sample period counter with end-of-period tick, plus the trigger pulse-width counter.
module temp_band_sample_timer
  import temp_band_pkg::*;
#(
  parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
  parameter int TRIG_W     = DEF_TRIG_W
) (
  input  logic clk,
  input  logic rst,
  input  logic pulse_run,
  output logic tick,
  output logic pulse_last
);

  localparam int PCW = cnt_w(SAMPLE_DIV);
  localparam int TCW = cnt_w(TRIG_W + 1);

  logic [PCW-1:0] period_cnt;
  logic [TCW-1:0] pulse_cnt;

  assign tick       = (period_cnt == PCW'(SAMPLE_DIV - 1));
  assign pulse_last = (pulse_cnt == TCW'(TRIG_W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       period_cnt <= '0;
    else if (tick) period_cnt <= '0;
    else           period_cnt <= period_cnt + PCW'(1);
  end

  // Held at zero outside the pulse so every pulse starts counting from a clean state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            pulse_cnt <= '0;
    else if (!pulse_run) pulse_cnt <= '0;
    else                pulse_cnt <= pulse_cnt + TCW'(1);
  end

endmodule

// File: rtl/temp_band_indicator.sv
// Temperature band classifier with DHT22 trigger pacing, downward hysteresis and stale detection.
// Optional macro TEMP_BAND_BLINK_EN blinks all LEDs while over-range or stale.
module temp_band_indicator
  import temp_band_pkg::*;
#(
  parameter int TEMP_W     = DEF_TEMP_W,
  parameter int NUM_BANDS  = DEF_NUM_BANDS,
  parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
  parameter int TRIG_W     = DEF_TRIG_W,
  parameter int HYST       = DEF_HYST,
  parameter int BLINK_DIV  = DEF_BLINK_DIV
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_BANDS*TEMP_W-1:0]   thr,
  input  logic                          temp_valid,
  input  logic [TEMP_W-1:0]             temp_data,
  output logic                          sensor_trigger,
  output logic [NUM_BANDS-1:0]          led,
  output logic [band_w(NUM_BANDS)-1:0]  band,
  output logic                          stale
);

  localparam int BW = band_w(NUM_BANDS);
  localparam int SW = TEMP_W + 1;

  state_t          state;
  logic            tick;
  logic            pulse_last;
  logic [TEMP_W-1:0] thr_a [NUM_BANDS];
  logic [TEMP_W-1:0] thr_below;
  logic [BW-1:0]   raw_band;
  logic [BW-1:0]   next_band;
  logic [SW-1:0]   t_plus_hyst;
  logic            dark;
  logic            blink_phase;

  temp_band_sample_timer #(
    .SAMPLE_DIV (SAMPLE_DIV),
    .TRIG_W     (TRIG_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .pulse_run  (state == TRIG),
    .tick       (tick),
    .pulse_last (pulse_last)
  );

  for (genvar k = 0; k < NUM_BANDS; k++) begin : g_thr
    assign thr_a[k] = thr[k*TEMP_W +: TEMP_W];
  end

  always_comb begin
    raw_band = BW'(NUM_BANDS);
    for (int k = NUM_BANDS - 1; k >= 0; k--) begin
      if (temp_data < thr_a[k]) raw_band = BW'(k);
    end
    thr_below = thr_a[0];
    for (int k = 0; k < NUM_BANDS; k++) begin
      if (band == BW'(k + 1)) thr_below = thr_a[k];
    end
    // Extra bit keeps t + HYST from wrapping near the top of the range.
    t_plus_hyst = {1'b0, temp_data} + SW'(HYST);
    next_band = band;
    if (raw_band > band)
      next_band = raw_band;
    else if (raw_band < band && t_plus_hyst < {1'b0, thr_below})
      next_band = raw_band;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      sensor_trigger <= 1'b0;
      band           <= '0;
      stale          <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (tick) begin
            state          <= TRIG;
            sensor_trigger <= 1'b1;
          end
        end
        TRIG: begin
          if (pulse_last) begin
            state          <= WAIT;
            sensor_trigger <= 1'b0;
          end
        end
        WAIT: begin
          if (temp_valid) begin
            band  <= next_band;
            stale <= 1'b0;
          end else if (tick) begin
            stale <= 1'b1;
          end
          // A tick always starts the next trigger, even when a sample lands on the same cycle.
          if (tick) begin
            state          <= TRIG;
            sensor_trigger <= 1'b1;
          end else if (temp_valid) begin
            state <= IDLE;
          end
        end
        default: begin
          state          <= IDLE;
          sensor_trigger <= 1'b0;
        end
      endcase
    end
  end

`ifdef TEMP_BAND_BLINK_EN
  localparam int BCW = cnt_w(BLINK_DIV);
  logic [BCW-1:0] blink_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BCW'(BLINK_DIV - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + BCW'(1);
    end
  end
`else
  // BLINK_DIV is at least 1, so the LEDs stay dark in this build.
  assign blink_phase = (BLINK_DIV == 0);
`endif

  assign dark = stale || (band == BW'(NUM_BANDS));

  always_comb begin
    led = '0;
    for (int k = 0; k < NUM_BANDS; k++) begin
      led[k] = dark ? blink_phase : (band == BW'(k));
    end
  end

endmodule

// File: tb/tb_temp_band_indicator.sv
// Bench for temp_band_indicator: directed literal checks plus randomized samples against a cycle-count model.
module tb_temp_band_indicator;

  localparam int TEMP_WD = 8;
  localparam int NB      = 3;
  localparam int SD      = 100;
  localparam int TRW     = 4;
  localparam int HY      = 2;
  localparam int BD      = 8;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NB*TEMP_WD-1:0]  thr;
  logic                   temp_valid = 1'b0;
  logic [TEMP_WD-1:0]     temp_data = '0;
  logic                   sensor_trigger;
  logic [NB-1:0]          led;
  logic [1:0]             band;
  logic                   stale;

  int total = 0;
  int bad   = 0;

  // Model state: edges since reset release, expected band/stale, sample taken this period.
  int ecount  = 0;
  int m_band  = 0;
  bit m_stale = 1'b1;
  bit got     = 1'b0;
  int thr_i [NB] = '{25, 30, 35};

  assign thr = {8'd35, 8'd30, 8'd25};

  always #5 clk = ~clk;

  temp_band_indicator #(
    .TEMP_W     (TEMP_WD),
    .NUM_BANDS  (NB),
    .SAMPLE_DIV (SD),
    .TRIG_W     (TRW),
    .HYST       (HY),
    .BLINK_DIV  (BD)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .thr            (thr),
    .temp_valid     (temp_valid),
    .temp_data      (temp_data),
    .sensor_trigger (sensor_trigger),
    .led            (led),
    .band           (band),
    .stale          (stale)
  );

  function automatic int model_next(input int t, input int b);
    int r;
    r = NB;
    for (int k = NB - 1; k >= 0; k--) if (t < thr_i[k]) r = k;
    if (r > b) return r;
    if (r < b && t + HY < thr_i[b-1]) return r;
    return b;
  endfunction

  function automatic int exp_trig();
    return (ecount >= SD && (ecount % SD) < TRW) ? 1 : 0;
  endfunction

  function automatic int exp_led();
    return (!m_stale && m_band < NB) ? (1 << m_band) : 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at edge %0d", name, act, exp, ecount);
    end
  endtask

  // Reference model: the sampling window of each period opens once the trigger has ended
  // and closes at the tick edge that ends the period (inclusive) or at the first sample.
  initial begin
    int  ph;
    bit  in_wait;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        ecount  = 0;
        m_band  = 0;
        m_stale = 1'b1;
        got     = 1'b0;
      end else begin
        ecount++;
        ph      = ecount % SD;
        in_wait = (ecount >= SD + TRW + 1) && (ph > TRW || ph == 0) && !got;
        if (in_wait && temp_valid) begin
          m_band  = model_next(int'(temp_data), m_band);
          m_stale = 1'b0;
          got     = 1'b1;
        end else if (in_wait && ph == 0) begin
          m_stale = 1'b1;
        end
        if (ph == 0) got = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("trigger", int'(sensor_trigger), exp_trig());
      check("band",    int'(band),           m_band);
      check("stale",   int'(stale),          int'(m_stale));
      check("led",     int'(led),            exp_led());
    end
  end

  task automatic wait_count(input int n);
    int guard;
    guard = 0;
    while (ecount != n && guard < 3000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    total++;
    if (ecount != n) begin
      bad++;
      $display("FAIL wait_count: reached edge %0d expected %0d", ecount, n);
    end
  endtask

  task automatic strobe(input int t);
    temp_valid = 1'b1;
    temp_data  = TEMP_WD'(t);
    @(posedge clk);
    #1;
    temp_valid = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // First trigger window and idle-state outputs.
    wait_count(99);  @(negedge clk); check("lit_trig_99",  int'(sensor_trigger), 0);
    wait_count(100); @(negedge clk); check("lit_trig_100", int'(sensor_trigger), 1);
    check("lit_stale_init", int'(stale), 1);
    check("lit_led_init",   int'(led),   0);
    wait_count(103); @(negedge clk); check("lit_trig_103", int'(sensor_trigger), 1);
    wait_count(104); @(negedge clk); check("lit_trig_104", int'(sensor_trigger), 0);

    wait_count(150); strobe(27); @(negedge clk);
    check("lit_27_band", int'(band), 1);
    check("lit_27_led",  int'(led),  2);
    check("lit_27_stale", int'(stale), 0);

    wait_count(250); strobe(24); @(negedge clk);
    check("lit_24_hold", int'(band), 1);
    wait_count(350); strobe(22); @(negedge clk);
    check("lit_22_band", int'(band), 0);
    check("lit_22_led",  int'(led),  1);

    wait_count(450); strobe(40); @(negedge clk);
    check("lit_40_band", int'(band), 3);
    check("lit_40_led",  int'(led),  0);

    // Period 501..600 has no sample.
    wait_count(600); @(negedge clk);
    check("lit_stale_set",  int'(stale), 1);
    check("lit_stale_led",  int'(led),   0);
    check("lit_stale_trig", int'(sensor_trigger), 1);
    wait_count(650); strobe(31); @(negedge clk);
    check("lit_31_stale", int'(stale), 0);
    check("lit_31_led",   int'(led),   4);

    // Sample lands on the tick edge 800.
    wait_count(799); strobe(37); @(negedge clk);
    check("lit_coin_band",  int'(band),  3);
    check("lit_coin_stale", int'(stale), 0);
    check("lit_coin_trig",  int'(sensor_trigger), 1);
    wait_count(850); strobe(28); @(negedge clk);
    check("lit_28_band", int'(band), 1);
    check("lit_28_led",  int'(led),  2);

    // Asynchronous reset in the middle of a trigger pulse.
    wait_count(901);
    #2 rst = 1'b1;
    #1;
    check("lit_rst_trig",  int'(sensor_trigger), 0);
    check("lit_rst_band",  int'(band),  0);
    check("lit_rst_stale", int'(stale), 1);
    check("lit_rst_led",   int'(led),   0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      temp_valid = ($urandom_range(0, 39) == 0);
      temp_data  = TEMP_WD'($urandom_range(10, 45));
      @(posedge clk);
      #1;
    end
    temp_valid = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/temp_band_indicator.md
# temp_band_indicator

Parametrised temperature band classifier driving one indicator LED per band. It paces the external DHT22 interface with a periodic trigger pulse and accepts a temperature sample over a valid strobe. Downward band changes use hysteresis, and a missed sample is flagged as stale. It replaces the fixed three-LED, free-running simulated-counter indicator in the sensor/LED subsystem.

## Interface
Parameters:
- TEMP_W, 8: temperature sample width, unsigned whole degrees.
- NUM_BANDS, 3: number of bands and LEDs (≥2). Band NUM_BANDS is over-range.
- SAMPLE_DIV, 100: clock cycles between trigger pulses (≥ TRIG_W+2).
- TRIG_W, 4: trigger pulse width in cycles (≥1).
- HYST, 2: hysteresis in degrees, applied to downward transitions only.
- BLINK_DIV, 8: half-period in cycles of the blink pattern (used only with the macro).

Ports:
- clk, in, 1: single clock, rising edge.
- rst, in, 1: reset, asynchronous, active-high.
- thr, in, NUM_BANDS*TEMP_W: ascending thresholds. Slice k is thr[k*TEMP_W +: TEMP_W]. Must be quasi-static.
- temp_valid, in, 1: one-cycle strobe, temp_data valid.
- temp_data, in, TEMP_W: sampled temperature.
- sensor_trigger, out, 1: DHT22 trigger pulse.
- led, out, NUM_BANDS: one-hot band indicator.
- band, out, $clog2(NUM_BANDS+1): current band index, 0..NUM_BANDS.
- stale, out, 1: no valid sample in the last period.

## Operation
- Raw band of t: the smallest k such that t < thr[k]. If no such k exists, the raw band is NUM_BANDS.
- Update rule on an accepted sample, with current band b and raw band r:
  - r > b: band ← r.
  - r < b: band ← r only when t + HYST < thr[b-1], using a TEMP_W+1-bit sum so there is no wrap. Otherwise band ← b.
  - r = b: no change.
- LED output: led[k] = 1 iff band == k and stale == 0. When band == NUM_BANDS or stale == 1, led is all zeros.
- FSM states:
  - IDLE: waits for a period tick, then goes to TRIG.
  - TRIG: sensor_trigger = 1 for TRIG_W cycles, then goes to WAIT.
  - WAIT: on temp_valid, update band, clear stale, go to IDLE. On a tick without temp_valid, set stale and go to TRIG.
- A tick and temp_valid in the same WAIT cycle: the sample is accepted and stale is cleared. The FSM goes directly to TRIG, so no period is skipped.
- temp_valid in IDLE or TRIG is ignored and has no effect.
- Period counter: free-runs 0..SAMPLE_DIV-1 and wraps. The tick is asserted at count SAMPLE_DIV-1. The counter is independent of the FSM state.

## Timing
- Reset values: sensor_trigger 0, led all 0, band 0, stale 1, FSM in IDLE, period counter 0, blink phase 0.
- The first tick occurs SAMPLE_DIV cycles after reset deassertion. sensor_trigger rises on the following cycle.
- sensor_trigger is registered and high for exactly TRIG_W consecutive cycles.
- Accept latency: a sample strobed on edge n is reflected in band, led and stale after edge n+1.
- Reset asserted mid-pulse or mid-wait: all outputs return to reset values immediately. No partial pulse completes.
- Threshold changes take effect on the next accepted sample only.

## Configuration
- Macro TEMP_BAND_BLINK_EN.
  - Defined: in the over-range or stale condition, all LEDs toggle together every BLINK_DIV cycles, driven by a blink counter reset to phase "off".
  - Undefined: in those conditions the LEDs are all 0, and the blink counter is not synthesised.
- Band, stale and trigger behaviour are identical in both builds.

## Structure
- Package temp_band_pkg:
  - FSM state enum (IDLE, TRIG, WAIT).
  - Band index width function.
  - Default parameter constants.
- Sub-module temp_band_sample_timer: period counter, tick generation, and TRIG_W pulse counter.
- Band classification, hysteresis, FSM and LED decode live in the top module.

## Test plan
All scenarios use TEMP_W=8, NUM_BANDS=3, thr={25,30,35}, SAMPLE_DIV=100, TRIG_W=4, HYST=2.
1. Reset release, no samples → first sensor_trigger high in cycles 101–104. stale stays 1 and led stays 000.
2. Sample 27 in WAIT → next cycle band=1, led=010, stale=0.
3. Sample 27, then 24, then 22 → band stays 1 after 24 (24+2 ≥ 25), then drops to 0 and led=001 after 22.
4. Sample 40 → band=3 and led=000. With TEMP_BAND_BLINK_EN defined, led toggles 000/111 every 8 cycles.
5. Valid sample, then no temp_valid for one full period → stale=1 and led=000 at the next tick. A new trigger is issued. A later sample of 31 clears stale and sets led=100.
6. temp_valid coincident with a WAIT tick → sample accepted, no stale, trigger rises the next cycle. rst pulsed mid-trigger → sensor_trigger drops asynchronously and all outputs return to reset values.
